// File: rtl/lfsr_noise_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | lfsr_noise_bank                                                             |
// | Rate-divided Fibonacci LFSR feeding an N-deep delay line of signed channels.|
// | Optional macro LFSR_SMOOTH_EN adds a one-pole smoother per channel.         |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module lfsr_noise_bank #(
   parameter int                LFSR_W       = 24,
   parameter logic [LFSR_W-1:0] TAPS         = 24'hE10000,
   parameter logic [LFSR_W-1:0] SEED_DEFAULT = 24'h0000AF,
   parameter int                N_CH         = 8,
   parameter int                OUT_W        = 16,
   parameter int                RATE_W       = 16,
   parameter int                SMOOTH_SH    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [RATE_W-1:0]      rate,
   input  logic                   seed_load,
   input  logic [LFSR_W-1:0]      seed,
   output logic                   step,
   output logic [N_CH*OUT_W-1:0]  out
);

   if (LFSR_W < 8 || LFSR_W > 32 || OUT_W > LFSR_W || N_CH < 1 || N_CH > 16 ||
       SMOOTH_SH < 1 || SMOOTH_SH > 8) begin : g_param_err
      $error("lfsr_noise_bank: parameter out of range");
   end

   logic [LFSR_W-1:0] state;
   logic [RATE_W-1:0] cnt;
   logic [OUT_W-1:0]  dly [N_CH];
   logic              lockup;
   logic              advance;
   logic              fb;

   assign lockup  = (state == '0);
   assign fb      = ^(state & TAPS);
   // Lockup recovery and seed loads both pre-empt a due advance.
   assign advance = !lockup && !seed_load && (cnt >= rate);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= SEED_DEFAULT;
         cnt   <= '0;
         step  <= 1'b0;
      end else begin
         step <= advance;
         if (lockup) begin
            state <= ~SEED_DEFAULT;
            cnt   <= '0;
         end else if (seed_load) begin
            state <= seed;
            cnt   <= '0;
         end else if (advance) begin
            state <= {state[LFSR_W-2:0], fb};
            cnt   <= '0;
         end else begin
            cnt   <= cnt + 1'b1;
         end
      end
   end

   // Only the top OUT_W bits of each delayed state are ever observed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N_CH; k++) dly[k] <= '0;
      end else if (advance) begin
         for (int k = N_CH-1; k > 0; k--) dly[k] <= dly[k-1];
         dly[0] <= state[LFSR_W-1 -: OUT_W];
      end
   end

`ifdef LFSR_SMOOTH_EN
   localparam int ACC_W = OUT_W + SMOOTH_SH;

   for (genvar k = 0; k < N_CH; k++) begin : g_smooth
      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W-1:0] x_sh;
      logic signed [ACC_W:0]   diff;
      logic signed [ACC_W:0]   delta;

      assign x_sh  = $signed({dly[k], {SMOOTH_SH{1'b0}}});
      assign diff  = $signed({x_sh[ACC_W-1], x_sh}) - $signed({acc[ACC_W-1], acc});
      assign delta = diff >>> SMOOTH_SH;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            acc <= '0;
         end else if (step && !seed_load) begin
            acc <= acc + delta[ACC_W-1:0];
         end
      end

      assign out[k*OUT_W +: OUT_W] = acc[ACC_W-1 -: OUT_W];
   end
`else
   for (genvar k = 0; k < N_CH; k++) begin : g_raw
      assign out[k*OUT_W +: OUT_W] = dly[k];
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_noise_bank.sv
`default_nettype none
// Scoreboard bench for lfsr_noise_bank: a reference model predicts step timing
// and channel values, a negedge monitor compares what the DUT presents.
module tb_lfsr_noise_bank;
   localparam int          LFSR_W       = 24;
   localparam int          N_CH         = 8;
   localparam int          OUT_W        = 16;
   localparam int          RATE_W       = 16;
   localparam int          SMOOTH_SH    = 2;
   localparam logic [23:0] TAPS         = 24'hE10000;
   localparam logic [23:0] SEED_DEFAULT = 24'h0000AF;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [RATE_W-1:0]     rate = '0;
   logic                  seed_load = 1'b0;
   logic [LFSR_W-1:0]     seed = '0;
   logic                  step;
   logic [N_CH*OUT_W-1:0] out;

   logic       reset8 = 1'b1;
   logic [3:0] rate8 = 4'd0;
   logic       seed_load8 = 1'b0;
   logic [7:0] seed8 = 8'd0;
   logic       step8;
   logic [7:0] out8;

   lfsr_noise_bank #(
      .LFSR_W(LFSR_W), .TAPS(TAPS), .SEED_DEFAULT(SEED_DEFAULT), .N_CH(N_CH),
      .OUT_W(OUT_W), .RATE_W(RATE_W), .SMOOTH_SH(SMOOTH_SH)
   ) dut (
      .clk(clk), .reset(reset), .rate(rate), .seed_load(seed_load),
      .seed(seed), .step(step), .out(out)
   );

   lfsr_noise_bank #(
      .LFSR_W(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .N_CH(1),
      .OUT_W(8), .RATE_W(4), .SMOOTH_SH(SMOOTH_SH)
   ) dut8 (
      .clk(clk), .reset(reset8), .rate(rate8), .seed_load(seed_load8),
      .seed(seed8), .step(step8), .out(out8)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                    at;
      logic [N_CH*OUT_W-1:0] val;
   } out_exp_t;

   int          step_q[$];
   out_exp_t    out_q[$];
   int          step_log[$];

   logic [23:0] m_state;
   int          m_cnt;
   logic [23:0] m_hist[$];
   bit          m_step_pending;
`ifdef LFSR_SMOOTH_EN
   int          m_y[N_CH];
`endif

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] lfsr_next(input logic [23:0] s);
      logic fb;
      fb = ^(s & TAPS);
      return {s[22:0], fb};
   endfunction

   function automatic logic [N_CH*OUT_W-1:0] raw_vec();
      logic [N_CH*OUT_W-1:0] v;
      v = '0;
      for (int k = 0; k < N_CH; k++) v[k*OUT_W +: OUT_W] = m_hist[k][23:8];
      return v;
   endfunction

   task automatic model_reset();
      m_state = SEED_DEFAULT;
      m_cnt   = 0;
      m_hist.delete();
      for (int k = 0; k < N_CH; k++) m_hist.push_back(24'h0);
      m_step_pending = 1'b0;
`ifdef LFSR_SMOOTH_EN
      for (int k = 0; k < N_CH; k++) m_y[k] = 0;
`endif
      step_q.delete();
      out_q.delete();
   endtask

   // Predict the effect of the coming rising edge for the current inputs, then
   // move on to the next falling edge.
   task automatic tick();
      int                    e;
      bit                    adv;
      out_exp_t              ent;
      e   = cyc + 1;
      adv = 1'b0;
`ifdef LFSR_SMOOTH_EN
      if (m_step_pending && !seed_load) begin
         ent.at = e;
         ent.val = '0;
         for (int k = 0; k < N_CH; k++) begin
            int x;
            int t;
            x = $signed(m_hist[k][23:8]);
            m_y[k] = m_y[k] + ((x * (1 << SMOOTH_SH) - m_y[k]) >>> SMOOTH_SH);
            t = m_y[k] >>> SMOOTH_SH;
            ent.val[k*OUT_W +: OUT_W] = t[15:0];
         end
         out_q.push_back(ent);
      end
`endif
      if (m_state == 24'h0) begin
         m_state = ~SEED_DEFAULT;
         m_cnt   = 0;
      end else if (seed_load) begin
         m_state = seed;
         m_cnt   = 0;
      end else if (m_cnt >= int'(rate)) begin
         adv = 1'b1;
         m_hist.push_front(m_state);
         void'(m_hist.pop_back());
         m_state = lfsr_next(m_state);
         m_cnt   = 0;
      end else begin
         m_cnt++;
      end
      m_step_pending = adv;
      if (adv) begin
         step_q.push_back(e);
`ifndef LFSR_SMOOTH_EN
         ent.at  = e;
         ent.val = raw_vec();
         out_q.push_back(ent);
`endif
      end
      @(negedge clk);
   endtask

   task automatic wait_cnt(input int target);
      int n;
      n = 0;
      while (m_cnt != target && n < 50) begin
         tick();
         n++;
      end
      if (m_cnt != target) begin
         checks++;
         failures++;
         $display("FAIL wait_cnt: count %0d never reached %0d", m_cnt, target);
      end
   endtask

   // Monitor: compares step every cycle and channel values when predicted.
   always @(negedge clk) begin
      if (!reset) begin
         check("reset_step", {127'd0, step}, 128'd0);
         check("reset_out", out, 128'd0);
      end else begin
         bit exp_step;
         exp_step = (step_q.size() > 0 && step_q[0] == cyc);
         if (exp_step) void'(step_q.pop_front());
         check("step", {127'd0, step}, {127'd0, exp_step});
         if (step) step_log.push_back(cyc);
         if (out_q.size() > 0 && out_q[0].at == cyc) begin
            out_exp_t ent;
            ent = out_q.pop_front();
            check("out", out, ent.val);
         end
      end
   end

`ifndef LFSR_SMOOTH_EN
   int n8 = 0;
   int ret8 = 0;
   always @(negedge clk) begin
      if (reset8 && step8) begin
         n8++;
         if (n8 <= 300) check("lfsr8_nonzero", {127'd0, (out8 != 8'h00)}, 128'd1);
         if (out8 == 8'h01 && n8 > 1 && ret8 == 0) ret8 = n8;
      end
   end
`endif

   initial begin
      int          s0;
      int          sa;
      int          rel;
      logic [23:0] s;

      #1;
      reset  = 1'b0;
      reset8 = 1'b0;
      model_reset();
      #1;
      check("reset_imm_step", {127'd0, step}, 128'd0);
      check("reset_imm_out", out, 128'd0);
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      reset8 = 1'b1;

      // rate=0 from reset: first channel values straight from the seed
      rate = 16'd0;
      tick();
      tick();
`ifndef LFSR_SMOOTH_EN
      check("ch0_after_2", {112'd0, out[15:0]}, 128'h0001);
`endif
      repeat (6) tick();
`ifndef LFSR_SMOOTH_EN
      check("ch7_after_8", {112'd0, out[7*16 +: 16]}, 128'h0000);
      check("ch0_after_8", {112'd0, out[15:0]}, 128'h0057);
`endif

      // rate=3 sustained for 50 steps
      rate = 16'd3;
      tick();
      s0 = step_log.size();
      repeat (200) tick();
      tick();
      check("rate3_count", 128'(step_log.size() - s0), 128'd50);
      for (int i = s0 + 1; i < s0 + 50 && i < step_log.size(); i++)
         check("rate3_period", 128'(step_log[i] - step_log[i-1]), 128'd4);

      // rate lowered mid-count when cnt=2
      wait_cnt(2);
      sa = step_log.size();
      rate = 16'd1;
      repeat (10) tick();
      check("rate_chg_count", {127'd0, (step_log.size() >= sa + 5)}, 128'd1);
      if (step_log.size() >= sa + 5) begin
         check("rate_chg_first", 128'(step_log[sa] - step_log[sa-1]), 128'd3);
         for (int i = sa + 1; i < sa + 5; i++)
            check("rate1_period", 128'(step_log[i] - step_log[i-1]), 128'd2);
      end

      // seed 0 triggers lockup recovery
      rate = 16'd2;
      wait_cnt(0);
      seed_load = 1'b1;
      seed = 24'h0;
      tick();
      seed_load = 1'b0;
      repeat (4) tick();
`ifndef LFSR_SMOOTH_EN
      check("lockup_step", {127'd0, step}, 128'd1);
      check("lockup_ch0", {112'd0, out[15:0]}, 128'hFFFF);
`endif
      repeat (12) tick();

      // seed load colliding with a due advance
      rate = 16'd0;
      s = 24'h5A5A5A;
      tick();
      seed_load = 1'b1;
      seed = s;
      tick();
      seed_load = 1'b0;
`ifndef LFSR_SMOOTH_EN
      check("seed_no_shift", out, raw_vec());
`endif
      tick();
`ifndef LFSR_SMOOTH_EN
      check("seed_ch0", {112'd0, out[15:0]}, {112'd0, s[23:8]});
`endif

      // randomized rates and seed loads
      for (int i = 0; i < 400; i++) begin
         if (i % 25 == 0) rate = 16'($urandom_range(4));
         seed_load = ($urandom_range(15) == 0);
         seed = ($urandom_range(3) == 0) ? 24'h0 : 24'($urandom);
         tick();
      end
      seed_load = 1'b0;
      repeat (4) tick();

      // reset mid-count
      rate = 16'd5;
      wait_cnt(3);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("midreset_step", {127'd0, step}, 128'd0);
      check("midreset_out", out, 128'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      rel = cyc;
      sa = step_log.size();
      repeat (7) tick();
      check("post_reset_steps", 128'(step_log.size() - sa), 128'd1);
      if (step_log.size() > sa)
         check("post_reset_first", 128'(step_log[sa] - rel), 128'd6);
      repeat (20) tick();

      #1;
      check("step_q_empty", 128'(step_q.size()), 128'd0);
      check("out_q_empty", 128'(out_q.size()), 128'd0);
`ifndef LFSR_SMOOTH_EN
      check("lfsr8_period", 128'(ret8), 128'd256);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
